lcd_timing_ctrl: RTL and testbench
==================================

# lcd_timing_ctrl

Sequences the RGB LCD panel from the 50 MHz system clock. It derives the 25 MHz pixel clock as a clk/2 toggle and scans horizontal and vertical counters on that pixel clock. From the counters it generates HS, VS and DE, plus a one-pixel-early data request with X/Y coordinates for the pixel source. It sits between the clock source and the display datapath and starts or stops scanning only on frame boundaries.

## Interface
- H_SYNC, 41: HS low width, pixels
- H_BACK, 2: horizontal back porch, pixels
- H_DISP, 480: active pixels per line
- H_FRONT, 2: horizontal front porch, pixels
- V_SYNC, 10: VS low width, lines
- V_BACK, 2: vertical back porch, lines
- V_DISP, 272: active lines
- V_FRONT, 2: vertical front porch, lines
- Derived: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Both must be ≤ 2048.

Ports:
- clk  in  1  50 MHz system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; level-sensitive, acted on only at frame boundaries.
- lcd_pclk  out  1  pixel clock, clk/2.
- pix_ce  out  1  one-clk pulse marking each pixel step (equals lcd_pclk).
- lcd_hs  out  1  horizontal sync, active low.
- lcd_vs  out  1  vertical sync, active low.
- lcd_de  out  1  data enable.
- data_req  out  1  pixel request, one pixel ahead of lcd_de.
- pixel_xpos  out  11  column of the requested pixel.
- pixel_ypos  out  11  row of the requested pixel.
- frame_start  out  1  one-clk pulse when a frame begins at h=0, v=0.
- busy  out  1  high while the state is RUN or STOPPING.

## Operation
- Phase bit `ph` toggles on every clk edge; its reset value is 0. lcd_pclk = ph and pix_ce = ph.
- A pixel step is a clk edge on which ph = 1. All state and counter updates occur only on pixel steps. Outputs therefore change on the pclk falling edge and are stable when the panel samples on the rising edge.
- h_cnt (11 b) runs 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt (11 b) wraps at V_TOTAL-1.
- States: IDLE, RUN, STOPPING.
  - IDLE: counters are held at 0. On a pixel step with en = 1, go to RUN and pulse frame_start. Counters are already at 0, and h_cnt increments on the next step.
  - RUN: counters advance. If en = 0 on a pixel step, go to STOPPING.
  - STOPPING: counters still advance. If en returns to 1, go back to RUN. On the wrap from (H_TOTAL-1, V_TOTAL-1), go to IDLE and do not pulse frame_start.
  - RUN wrapping from (H_TOTAL-1, V_TOTAL-1) to (0, 0) pulses frame_start.
- Decode is combinational from the registered counters and applies in RUN and STOPPING only:
  - lcd_hs = 0 when h_cnt < H_SYNC.
  - lcd_vs = 0 when v_cnt < V_SYNC.
  - lcd_de = 1 when H_SYNC+H_BACK ≤ h_cnt < H_SYNC+H_BACK+H_DISP and V_SYNC+V_BACK ≤ v_cnt < V_SYNC+V_BACK+V_DISP.
  - data_req uses the same window with the horizontal bounds reduced by 1.
  - pixel_xpos = h_cnt - (H_SYNC+H_BACK-1) while data_req = 1, else 0.
  - pixel_ypos = v_cnt - (V_SYNC+V_BACK) while data_req = 1, else 0.
- In IDLE: lcd_hs = 1, lcd_vs = 1, lcd_de = 0, data_req = 0, xpos = 0, ypos = 0.
- Reset values: ph = 0, lcd_pclk = 0, pix_ce = 0, state IDLE, counters 0, lcd_hs = 1, lcd_vs = 1, lcd_de = 0, data_req = 0, xpos = 0, ypos = 0, frame_start = 0, busy = 0.
- Reset asserted mid-frame returns all of the above immediately and asynchronously. After release, lcd_pclk toggles from the first clk edge.

## Timing
- Pixel period is 2 clk.
- en is sampled only on pixel steps. Latency from en rising to frame_start is 1 or 2 clk, depending on ph.
- frame_start is high for exactly one clk: the clk after the pixel step that produced h = 0, v = 0, i.e. while ph = 0.
- data_req leads lcd_de by exactly one pixel (2 clk). xpos/ypos are valid whenever data_req = 1.
- A line is H_TOTAL pixels; a frame is H_TOTAL × V_TOTAL pixels.
- If en is deasserted during the last pixel of a frame, one further full frame is scanned: STOPPING is entered on that step and ends only at the next frame wrap.

## Test plan
Small parameters for all scenarios: H = 2/1/4/1 (H_TOTAL = 8), V = 1/1/2/1 (V_TOTAL = 5). One frame = 40 pixels = 80 clk.
- Reset and idle: hold rst_n = 0 for 5 clk, then release with en = 0 → lcd_pclk toggles every clk; hs = vs = 1; de = data_req = frame_start = busy = 0 for 100 clk.
- Start: raise en → frame_start pulses once; busy = 1. hs is low for h = 0..1 of each line; vs is low for all of v = 0.
- Active window: data_req = 1 at h = 2..5 on v = 2..3, with xpos = 0..3 and ypos = 0..1. lcd_de = 1 at h = 3..6 on the same rows. Total 8 de pixels per frame.
- Continuous: en held high for 3 frames → frame_start pulses exactly 80 clk apart; counters wrap cleanly.
- Stop and re-enable: drop en mid-frame → frame completes and busy falls after the last pixel with no extra frame_start. Separately, drop en and re-raise it within the same frame → scanning continues uninterrupted.
- Mid-frame reset: assert rst_n = 0 at v = 2, h = 4 → all outputs return to reset values within the same clk. After release with en = 1 → a fresh frame starts at (0, 0) with a frame_start pulse.

Source files
------------

// File: rtl/lcd_timing_ctrl.sv
// RGB LCD timing generator: clk/2 pixel clock, H/V scan counters, sync/DE decode
// and a one-pixel-early data request; scanning starts and stops on frame boundaries.
module lcd_timing_ctrl #(
    parameter int unsigned H_SYNC  = 41,
    parameter int unsigned H_BACK  = 2,
    parameter int unsigned H_DISP  = 480,
    parameter int unsigned H_FRONT = 2,
    parameter int unsigned V_SYNC  = 10,
    parameter int unsigned V_BACK  = 2,
    parameter int unsigned V_DISP  = 272,
    parameter int unsigned V_FRONT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        lcd_pclk,
    output logic        pix_ce,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start,
    output logic        busy
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_END   = 11'(H_SYNC);
    localparam logic [10:0] VS_END   = 11'(V_SYNC);
    localparam logic [10:0] HDE_BEG  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HDE_END  = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] HREQ_BEG = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] HREQ_END = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] VDE_BEG  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VDE_END  = 11'(V_SYNC + V_BACK + V_DISP);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

    state_e      state_q, state_d;
    logic        ph_q;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        frame_start_q, frame_start_d;
    logic [10:0] h_adv, v_adv;
    logic        frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q          <= 1'b0;
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            ph_q          <= ~ph_q;
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        h_adv = h_cnt_q + 11'd1;
        v_adv = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_adv = '0;
            v_adv = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
        end
    end

    assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    // frame_start is only ever set on a pixel step, so it clears on the following clk
    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;
        if (ph_q) begin
            unique case (state_q)
                IDLE: begin
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                    if (en) begin
                        state_d       = RUN;
                        frame_start_d = 1'b1;
                    end
                end
                RUN: begin
                    h_cnt_d       = h_adv;
                    v_cnt_d       = v_adv;
                    frame_start_d = frame_end;
                    if (!en) state_d = STOPPING;
                end
                STOPPING: begin
                    h_cnt_d = h_adv;
                    v_cnt_d = v_adv;
                    if (en) begin
                        state_d       = RUN;
                        frame_start_d = frame_end;
                    end else if (frame_end) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic active, h_de, v_de, h_req;

    always_comb begin
        active = (state_q != IDLE);
        h_de   = (h_cnt_q >= HDE_BEG)  && (h_cnt_q < HDE_END);
        h_req  = (h_cnt_q >= HREQ_BEG) && (h_cnt_q < HREQ_END);
        v_de   = (v_cnt_q >= VDE_BEG)  && (v_cnt_q < VDE_END);

        lcd_hs     = !(active && (h_cnt_q < HS_END));
        lcd_vs     = !(active && (v_cnt_q < VS_END));
        lcd_de     = active && h_de && v_de;
        data_req   = active && h_req && v_de;
        pixel_xpos = data_req ? h_cnt_q - HREQ_BEG : '0;
        pixel_ypos = data_req ? v_cnt_q - VDE_BEG : '0;
    end

    assign lcd_pclk    = ph_q;
    assign pix_ce      = ph_q;
    assign frame_start = frame_start_q;
    assign busy        = active;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl with an 8x5 pixel frame (H 2/1/4/1, V 1/1/2/1).
module tb_lcd_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        lcd_pclk, pix_ce, lcd_hs, lcd_vs, lcd_de, data_req, frame_start, busy;
    logic [10:0] pixel_xpos, pixel_ypos;

    always #5 clk = ~clk;

    lcd_timing_ctrl #(
        .H_SYNC (2), .H_BACK (1), .H_DISP (4), .H_FRONT (1),
        .V_SYNC (1), .V_BACK (1), .V_DISP (2), .V_FRONT (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .lcd_pclk    (lcd_pclk),
        .pix_ce      (pix_ce),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .lcd_de      (lcd_de),
        .data_req    (data_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .frame_start (frame_start),
        .busy        (busy)
    );

    localparam int NEVER = 1 << 30;

    int n_cmp  = 0;
    int n_bad  = 0;
    int kk     = 0;      // clk count since the current frame_start edge
    int stop_k = NEVER;  // kk at which scanning is expected to be idle again
    int de_cnt = 0;
    int exp_ph;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s (k=%0d): got %0d, expected %0d", tag, kk, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string where);
        check_eq({where, ".pclk"}, int'(lcd_pclk), 0);
        check_eq({where, ".pix_ce"}, int'(pix_ce), 0);
        check_eq({where, ".hs"}, int'(lcd_hs), 1);
        check_eq({where, ".vs"}, int'(lcd_vs), 1);
        check_eq({where, ".de"}, int'(lcd_de), 0);
        check_eq({where, ".req"}, int'(data_req), 0);
        check_eq({where, ".xpos"}, int'(pixel_xpos), 0);
        check_eq({where, ".ypos"}, int'(pixel_ypos), 0);
        check_eq({where, ".fs"}, int'(frame_start), 0);
        check_eq({where, ".busy"}, int'(busy), 0);
    endtask

    // Expected outputs at sample kk, derived from the hand-computed 8x5 timing.
    task automatic check_point();
        int p, h, v;
        int ehs, evs, ede, ereq, ex, ey, efs, ebusy;
        ehs = 1; evs = 1; ede = 0; ereq = 0; ex = 0; ey = 0; efs = 0; ebusy = 0;
        if (kk < stop_k) begin
            p     = kk / 2;
            h     = p % 8;
            v     = (p / 8) % 5;
            ehs   = (h < 2) ? 0 : 1;
            evs   = (v < 1) ? 0 : 1;
            ede   = (h >= 3 && h <= 6 && v >= 2 && v <= 3) ? 1 : 0;
            ereq  = (h >= 2 && h <= 5 && v >= 2 && v <= 3) ? 1 : 0;
            ex    = (ereq == 1) ? h - 2 : 0;
            ey    = (ereq == 1) ? v - 2 : 0;
            efs   = (kk % 80 == 0) ? 1 : 0;
            ebusy = 1;
        end
        check_eq("pclk", int'(lcd_pclk), kk % 2);
        check_eq("pix_ce", int'(pix_ce), kk % 2);
        check_eq("hs", int'(lcd_hs), ehs);
        check_eq("vs", int'(lcd_vs), evs);
        check_eq("de", int'(lcd_de), ede);
        check_eq("data_req", int'(data_req), ereq);
        check_eq("xpos", int'(pixel_xpos), ex);
        check_eq("ypos", int'(pixel_ypos), ey);
        check_eq("frame_start", int'(frame_start), efs);
        check_eq("busy", int'(busy), ebusy);
        if (kk < stop_k) begin
            if (kk % 80 == 0) de_cnt = 0;
            if (kk % 2 == 0 && lcd_de) de_cnt++;
            if (kk % 80 == 79) check_eq("de_per_frame", de_cnt, 8);
        end
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) begin
            check_point();
            tick();
            kk++;
        end
    endtask

    // Raise en from idle; frame_start lands on the second edge when ph is 0.
    task automatic start_frame();
        if (lcd_pclk) tick();
        en = 1'b1;
        tick();
        check_eq("start.busy_early", int'(busy), 0);
        check_eq("start.fs_early", int'(frame_start), 0);
        tick();
        kk     = 0;
        stop_k = NEVER;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (5) tick();
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: pclk toggles from the first edge, nothing else moves
        exp_ph = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            exp_ph = 1 - exp_ph;
            check_eq("idle.pclk", int'(lcd_pclk), exp_ph);
            check_eq("idle.hs", int'(lcd_hs), 1);
            check_eq("idle.vs", int'(lcd_vs), 1);
            check_eq("idle.de", int'(lcd_de), 0);
            check_eq("idle.req", int'(data_req), 0);
            check_eq("idle.fs", int'(frame_start), 0);
            check_eq("idle.busy", int'(busy), 0);
        end

        // Three continuous frames, then the start of a fourth
        start_frame();
        scan(260);

        // Drop en mid-frame: frame completes, then idle with no extra frame_start
        en     = 1'b0;
        stop_k = 320;
        scan(80);

        // Drop and re-raise en within one frame: scanning is uninterrupted
        start_frame();
        scan(20);
        en = 1'b0;
        scan(10);
        en = 1'b1;
        scan(170);

        // kk = 200 is v=2, h=4 of the third frame; reset asynchronously there
        check_point();
        check_eq("pre_rst.de", int'(lcd_de), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rel.pclk", int'(lcd_pclk), 1);
        check_eq("rel.busy", int'(busy), 0);
        check_eq("rel.fs", int'(frame_start), 0);
        tick();
        kk     = 0;
        stop_k = NEVER;
        scan(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
